// File: rtl/tracker_pkg.sv
// Shared types for the multi-axis tracker: axis state encoding and drive codes.
package tracker_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOVE_POS = 3'd1,
        MOVE_NEG = 3'd2,
        BRAKE    = 3'd3,
        FAULT    = 3'd4
    } axis_state_t;

    localparam logic [1:0] DRV_OFF  = 2'b00;
    localparam logic [1:0] DRV_SLOW = 2'b01;
    localparam logic [1:0] DRV_FAST = 2'b10;

endpackage

// File: rtl/tracker_axis.sv
// One tracker axis: error source mux, magnitude, drive FSM, run watchdog and
// brake settle timer. Drives, busy and fault are registered from the next
// state, so they always agree with the state register.
module tracker_axis
    import tracker_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEADBAND      = 4,
    parameter int STOP_BAND     = 2,
    parameter int FAST_THRESH   = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_RUN       = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_mode,
    input  logic             fault_clr,
    input  logic [WIDTH-1:0] sens_a,
    input  logic [WIDTH-1:0] sens_b,
    input  logic [WIDTH-1:0] angle_manual,
    input  logic [WIDTH-1:0] angle_actual,
    output logic [1:0]       drive_pos,
    output logic [1:0]       drive_neg,
    output logic             busy,
    output logic             fault
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [WIDTH-1:0] DB_M       = WIDTH'(DEADBAND);
    localparam logic [WIDTH-1:0] SB_M       = WIDTH'(STOP_BAND);
    localparam logic [WIDTH-1:0] FT_M       = WIDTH'(FAST_THRESH);
    localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(MAX_RUN - 1);
    localparam logic [RUN_W-1:0] RUN_SAT    = RUN_W'(MAX_RUN);
    localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYCLES - 1);

    axis_state_t        state;
    axis_state_t        next_state;
    logic [RUN_W-1:0]   run_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               auto_prev;

    logic signed [WIDTH:0] err;
    logic [WIDTH-1:0]      mag;
    logic                  err_neg;
    logic                  err_pos;
    logic                  mode_toggle;
    logic                  timeout;

    logic [1:0] speed;
    logic [1:0] drive_pos_d;
    logic [1:0] drive_neg_d;
    logic       busy_d;
    logic       fault_d;

    // Zero-extended operands give a WIDTH+1 signed difference that cannot overflow.
    assign err = auto_mode ? $signed({1'b0, sens_a} - {1'b0, sens_b})
                           : $signed({1'b0, angle_manual} - {1'b0, angle_actual});
    assign err_neg     = err[WIDTH];
    assign err_pos     = !err[WIDTH] && (|err[WIDTH-1:0]);
    assign mag         = err_neg ? WIDTH'(-err) : err[WIDTH-1:0];
    assign mode_toggle = (auto_mode != auto_prev);
    // Current clock is the MAX_RUN-th consecutive MOVE clock.
    assign timeout     = (run_cnt >= RUN_LAST);

    // State register with run watchdog, settle timer and mode history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            run_cnt    <= '0;
            settle_cnt <= '0;
            auto_prev  <= 1'b0;
        end else begin
            state     <= next_state;
            auto_prev <= auto_mode;
            if (next_state == IDLE || next_state == BRAKE) begin
                run_cnt <= '0;
            end else if ((state == MOVE_POS || state == MOVE_NEG) && run_cnt != RUN_SAT) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
            if (state == BRAKE && next_state == BRAKE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // Next-state logic; the watchdog takes priority over any brake condition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mag > DB_M && err_pos) begin
                    next_state = MOVE_POS;
                end else if (mag > DB_M && err_neg) begin
                    next_state = MOVE_NEG;
                end
            end
            MOVE_POS: begin
                if (timeout) begin
                    next_state = FAULT;
                end else if (mag <= SB_M || err_neg || mode_toggle) begin
                    next_state = BRAKE;
                end
            end
            MOVE_NEG: begin
                if (timeout) begin
                    next_state = FAULT;
                end else if (mag <= SB_M || !err_neg || mode_toggle) begin
                    next_state = BRAKE;
                end
            end
            BRAKE: begin
                if (settle_cnt == SETTLE_END) begin
                    next_state = IDLE;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state; only one side can ever be driven.
    always_comb begin
        drive_pos_d = DRV_OFF;
        drive_neg_d = DRV_OFF;
        speed       = (mag > FT_M) ? DRV_FAST : DRV_SLOW;
        busy_d      = (next_state != IDLE);
        fault_d     = (next_state == FAULT);
        if (next_state == MOVE_POS) begin
            drive_pos_d = speed;
        end else if (next_state == MOVE_NEG) begin
            drive_neg_d = speed;
        end
    end

    // Output register, aligned with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_pos <= DRV_OFF;
            drive_neg <= DRV_OFF;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            drive_pos <= drive_pos_d;
            drive_neg <= drive_neg_d;
            busy      <= busy_d;
            fault     <= fault_d;
        end
    end

endmodule

// File: rtl/tracker_multi_axis.sv
// N-axis tracker motion control: registers every input once, then runs one
// independent tracker_axis per axis and concatenates their outputs.
module tracker_multi_axis
    import tracker_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int N_AXES        = 2,
    parameter int DEADBAND      = 4,
    parameter int STOP_BAND     = 2,
    parameter int FAST_THRESH   = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_RUN       = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    auto_mode,
    input  logic                    fault_clr,
    input  logic [N_AXES*WIDTH-1:0] sens_a,
    input  logic [N_AXES*WIDTH-1:0] sens_b,
    input  logic [N_AXES*WIDTH-1:0] angle_manual,
    input  logic [N_AXES*WIDTH-1:0] angle_actual,
    output logic [2*N_AXES-1:0]     drive_pos,
    output logic [2*N_AXES-1:0]     drive_neg,
    output logic [N_AXES-1:0]       busy,
    output logic [N_AXES-1:0]       fault
);

    logic                    auto_q;
    logic                    fault_clr_q;
    logic [N_AXES*WIDTH-1:0] sens_a_q;
    logic [N_AXES*WIDTH-1:0] sens_b_q;
    logic [N_AXES*WIDTH-1:0] angle_manual_q;
    logic [N_AXES*WIDTH-1:0] angle_actual_q;

    // Input register stage shared by all axes.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_q         <= 1'b0;
            fault_clr_q    <= 1'b0;
            sens_a_q       <= '0;
            sens_b_q       <= '0;
            angle_manual_q <= '0;
            angle_actual_q <= '0;
        end else begin
            auto_q         <= auto_mode;
            fault_clr_q    <= fault_clr;
            sens_a_q       <= sens_a;
            sens_b_q       <= sens_b;
            angle_manual_q <= angle_manual;
            angle_actual_q <= angle_actual;
        end
    end

    for (genvar i = 0; i < N_AXES; i++) begin : gen_axis
        tracker_axis #(
            .WIDTH         (WIDTH),
            .DEADBAND      (DEADBAND),
            .STOP_BAND     (STOP_BAND),
            .FAST_THRESH   (FAST_THRESH),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .MAX_RUN       (MAX_RUN)
        ) u_axis (
            .clk          (clk),
            .rst          (rst),
            .auto_mode    (auto_q),
            .fault_clr    (fault_clr_q),
            .sens_a       (sens_a_q[i*WIDTH +: WIDTH]),
            .sens_b       (sens_b_q[i*WIDTH +: WIDTH]),
            .angle_manual (angle_manual_q[i*WIDTH +: WIDTH]),
            .angle_actual (angle_actual_q[i*WIDTH +: WIDTH]),
            .drive_pos    (drive_pos[2*i +: 2]),
            .drive_neg    (drive_neg[2*i +: 2]),
            .busy         (busy[i]),
            .fault        (fault[i])
        );
    end

endmodule

// File: tb/tb_tracker_multi_axis.sv
// Directed bench for tracker_multi_axis (2 axes, MAX_RUN = 20).
module tb_tracker_multi_axis;

    localparam int W = 16;
    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic           auto_mode;
    logic           fault_clr;
    logic [N*W-1:0] sens_a;
    logic [N*W-1:0] sens_b;
    logic [N*W-1:0] angle_manual;
    logic [N*W-1:0] angle_actual;
    logic [2*N-1:0] drive_pos;
    logic [2*N-1:0] drive_neg;
    logic [N-1:0]   busy;
    logic [N-1:0]   fault;

    int checks = 0;
    int errors = 0;

    tracker_multi_axis #(
        .WIDTH   (W),
        .N_AXES  (N),
        .MAX_RUN (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .auto_mode    (auto_mode),
        .fault_clr    (fault_clr),
        .sens_a       (sens_a),
        .sens_b       (sens_b),
        .angle_manual (angle_manual),
        .angle_actual (angle_actual),
        .drive_pos    (drive_pos),
        .drive_neg    (drive_neg),
        .busy         (busy),
        .fault        (fault)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Both sides of one axis must never be driven at the same time.
    task automatic check_invariant();
        for (int i = 0; i < N; i++) begin
            checks++;
            assert (!(drive_pos[2*i +: 2] != 2'b00 && drive_neg[2*i +: 2] != 2'b00)) else begin
                errors++;
                $error("FAIL invariant axis%0d: pos %0h neg %0h, required one side 0",
                       i, drive_pos[2*i +: 2], drive_neg[2*i +: 2]);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_invariant();
        end
    endtask

    task automatic check_axis(input string tag, input int ax, input logic [1:0] pos,
                              input logic [1:0] neg, input logic bsy, input logic flt);
        check($sformatf("%s.pos%0d", tag, ax), 32'(drive_pos[2*ax +: 2]), 32'(pos));
        check($sformatf("%s.neg%0d", tag, ax), 32'(drive_neg[2*ax +: 2]), 32'(neg));
        check($sformatf("%s.busy%0d", tag, ax), 32'(busy[ax]), 32'(bsy));
        check($sformatf("%s.fault%0d", tag, ax), 32'(fault[ax]), 32'(flt));
    endtask

    task automatic set_sens(input int ax, input logic [W-1:0] a, input logic [W-1:0] b);
        sens_a[ax*W +: W] = a;
        sens_b[ax*W +: W] = b;
    endtask

    task automatic set_angle(input int ax, input logic [W-1:0] m, input logic [W-1:0] act);
        angle_manual[ax*W +: W] = m;
        angle_actual[ax*W +: W] = act;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        auto_mode    = 1'b0;
        fault_clr    = 1'b0;
        sens_a       = '0;
        sens_b       = '0;
        angle_manual = '0;
        angle_actual = '0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset and hold with random inputs
        rst          = 1'b1;
        auto_mode    = 1'($urandom_range(0, 1));
        fault_clr    = 1'($urandom_range(0, 1));
        sens_a       = {N*W{1'b0}} | $urandom;
        sens_b       = {N*W{1'b0}} | $urandom;
        angle_manual = {N*W{1'b0}} | $urandom;
        angle_actual = {N*W{1'b0}} | $urandom;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_axis("rst_hold", 0, 2'b00, 2'b00, 1'b0, 1'b0);
            check_axis("rst_hold", 1, 2'b00, 2'b00, 1'b0, 1'b0);
        end
        rst          = 1'b0;
        auto_mode    = 1'b0;
        fault_clr    = 1'b0;
        sens_a       = '0;
        sens_b       = '0;
        angle_manual = '0;
        angle_actual = '0;
        step(3);
        check_axis("idle_after_rst", 0, 2'b00, 2'b00, 1'b0, 1'b0);
        check_axis("idle_after_rst", 1, 2'b00, 2'b00, 1'b0, 1'b0);

        // Auto slow move on axis 0, then stop band -> brake 8 clocks -> idle
        auto_mode = 1'b1;
        set_sens(0, 16'd30, 16'd20);
        step(1);
        check_axis("auto_lat1", 0, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1);
        check_axis("auto_slow", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        check_axis("auto_slow", 1, 2'b00, 2'b00, 1'b0, 1'b0);
        set_sens(0, 16'd30, 16'd29);
        step(1);
        check_axis("stop_lat1", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check_axis($sformatf("brake%0d", k), 0, 2'b00, 2'b00, 1'b1, 1'b0);
        end
        step(1);
        check_axis("brake_done", 0, 2'b00, 2'b00, 1'b0, 1'b0);

        // Manual fast move on axis 1, then slow, then mode toggle -> brake
        do_reset();
        set_angle(1, 16'd200, 16'd40);
        step(2);
        check_axis("man_fast", 1, 2'b10, 2'b00, 1'b1, 1'b0);
        check_axis("man_fast", 0, 2'b00, 2'b00, 1'b0, 1'b0);
        set_angle(1, 16'd200, 16'd150);
        step(1);
        check_axis("man_lat1", 1, 2'b10, 2'b00, 1'b1, 1'b0);
        step(1);
        check_axis("man_slow", 1, 2'b01, 2'b00, 1'b1, 1'b0);
        set_sens(1, 16'd100, 16'd0);
        auto_mode = 1'b1;
        step(2);
        check_axis("mode_toggle", 1, 2'b00, 2'b00, 1'b1, 1'b0);

        // Reversal: MOVE_POS -> BRAKE -> IDLE -> MOVE_NEG fast
        do_reset();
        auto_mode = 1'b1;
        set_sens(0, 16'd30, 16'd20);
        step(2);
        check_axis("rev_start", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        set_sens(0, 16'd10, 16'd100);
        step(1);
        check_axis("rev_lat1", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check_axis($sformatf("rev_brake%0d", k), 0, 2'b00, 2'b00, 1'b1, 1'b0);
        end
        step(1);
        check_axis("rev_idle", 0, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1);
        check_axis("rev_neg", 0, 2'b00, 2'b10, 1'b1, 1'b0);

        // Reset mid-move: drives off on the next clock, no brake
        rst = 1'b1;
        step(1);
        check_axis("rst_mid", 0, 2'b00, 2'b00, 1'b0, 1'b0);

        // Watchdog on axis 0, axis 1 unaffected, then fault clear and restart
        do_reset();
        auto_mode = 1'b1;
        set_sens(0, 16'd30, 16'd20);
        step(2);
        check_axis("wd_start", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        step(19);
        check_axis("wd_last_move", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        step(1);
        check_axis("wd_fault", 0, 2'b00, 2'b00, 1'b1, 1'b1);
        check_axis("wd_other", 1, 2'b00, 2'b00, 1'b0, 1'b0);
        step(3);
        check_axis("wd_sticky", 0, 2'b00, 2'b00, 1'b1, 1'b1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(1);
        check_axis("wd_clr", 0, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1);
        check_axis("wd_restart", 0, 2'b01, 2'b00, 1'b1, 1'b0);

        // Deadband edges
        do_reset();
        auto_mode = 1'b1;
        set_sens(0, 16'd24, 16'd20);
        step(4);
        check_axis("db_plus4", 0, 2'b00, 2'b00, 1'b0, 1'b0);
        set_sens(0, 16'd25, 16'd20);
        step(2);
        check_axis("db_plus5", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        do_reset();
        auto_mode = 1'b1;
        set_sens(0, 16'd20, 16'd25);
        step(2);
        check_axis("db_minus5", 0, 2'b00, 2'b01, 1'b1, 1'b0);

        // Timeout and stop band in the same clock: fault wins
        do_reset();
        auto_mode = 1'b1;
        set_sens(0, 16'd30, 16'd20);
        step(20);
        set_sens(0, 16'd30, 16'd29);
        step(1);
        check_axis("tie_last_move", 0, 2'b01, 2'b00, 1'b1, 1'b0);
        step(1);
        check_axis("tie_fault", 0, 2'b00, 2'b00, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
